uart_alu_interface: RTL

UART_ALU_INTERFACE -- requirements
Module: uart_alu_interface

---
 rtl/uart_alu_interface.sv | 101 ++++++++++
 1 files changed

// File: rtl/uart_alu_interface.sv
// Sequences UART bytes into ALU operands A, B and an opcode, then sends the ALU result
// back out through the transmitter. Bytes that arrive mid-operation set a sticky overrun flag.
module uart_alu_interface #(
  parameter int N_BITS_DATA  = 8,
  parameter int N_BITS_OP    = 6,
  parameter int N_BITS_STATE = 5
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   rx_done_tick,
  input  logic [N_BITS_DATA-1:0] rx_data,
  input  logic [N_BITS_DATA-1:0] alu_result,
  input  logic                   tx_done_tick,
  output logic [N_BITS_DATA-1:0] alu_data_a,
  output logic [N_BITS_DATA-1:0] alu_data_b,
  output logic [N_BITS_OP-1:0]   alu_op,
  output logic                   tx_start,
  output logic [N_BITS_DATA-1:0] tx_data,
  output logic                   busy,
  output logic                   overrun
);

  // WAIT_A is the all-zero code; the other five states each own one bit.
  typedef enum logic [N_BITS_STATE-1:0] {
    WAIT_A  = N_BITS_STATE'(0),
    WAIT_B  = N_BITS_STATE'(1),
    WAIT_OP = N_BITS_STATE'(2),
    EXEC    = N_BITS_STATE'(4),
    SEND    = N_BITS_STATE'(8),
    WAIT_TX = N_BITS_STATE'(16)
  } state_t;

  state_t state_q, state_d;
  logic   load_a, load_b, load_op, load_tx;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values, independent of the order the always blocks are evaluated.
  always_ff @(posedge clock) begin
    if (!reset) state_q <= WAIT_A;
    else        state_q <= state_d;
  end

  // NOTE: every output of this block gets a default before the case, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    load_a   = 1'b0;
    load_b   = 1'b0;
    load_op  = 1'b0;
    load_tx  = 1'b0;
    tx_start = 1'b0;
    busy     = 1'b0;
    case (state_q)
      WAIT_A: if (rx_done_tick) begin
        load_a  = 1'b1;
        state_d = WAIT_B;
      end
      WAIT_B: if (rx_done_tick) begin
        load_b  = 1'b1;
        state_d = WAIT_OP;
      end
      WAIT_OP: if (rx_done_tick) begin
        load_op = 1'b1;
        state_d = EXEC;
      end
      EXEC: begin
        busy    = 1'b1;
        load_tx = 1'b1;
        state_d = SEND;
      end
      SEND: begin
        busy     = 1'b1;
        tx_start = 1'b1;
        state_d  = WAIT_TX;
      end
      WAIT_TX: begin
        busy = 1'b1;
        if (tx_done_tick) state_d = WAIT_A;
      end
      default: state_d = WAIT_A;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      alu_data_a <= '0;
      alu_data_b <= '0;
      alu_op     <= '0;
      tx_data    <= '0;
      overrun    <= 1'b0;
    end else begin
      if (load_a)  alu_data_a <= rx_data;
      if (load_b)  alu_data_b <= rx_data;
      if (load_op) alu_op     <= rx_data[N_BITS_OP-1:0];
      if (load_tx) tx_data    <= alu_result;
      // A byte arriving while busy is dropped; only the flag records it.
      if (rx_done_tick && busy) overrun <= 1'b1;
    end
  end

endmodule
